// File: rtl/shift_pkg.sv
// Shared types and constants for the sequential right shifter.
package shift_pkg;

   localparam int WIDTH_DEFAULT   = 32;
   localparam int SHAMT_W_DEFAULT = 5;
   localparam int MULTIBIT_STEP   = 4;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

endpackage

// File: rtl/shift_right_seq_if.sv
// Request/result bundle between the ALU control and the sequential right shifter.
interface shift_right_seq_if
   import shift_pkg::*;
#(
   parameter int WIDTH   = WIDTH_DEFAULT,
   parameter int SHAMT_W = SHAMT_W_DEFAULT
);

   logic               start;
   logic               arith;
   logic [SHAMT_W-1:0] shamt;
   logic [WIDTH-1:0]   value_in;
   logic               busy;
   logic               done;
   logic [WIDTH-1:0]   value_out;

   modport master (
      output start, arith, shamt, value_in,
      input  busy, done, value_out
   );

   modport slave (
      input  start, arith, shamt, value_in,
      output busy, done, value_out
   );

endinterface

// File: rtl/shift_right_step.sv
// Combinational single-step right shifter: zero fill (SRL) or sign fill (SRA).
module shift_right_step
   import shift_pkg::*;
#(
   parameter int WIDTH   = WIDTH_DEFAULT,
   parameter int SHAMT_W = SHAMT_W_DEFAULT
) (
   input  logic [WIDTH-1:0]   value,
   input  logic               arith,
   input  logic [SHAMT_W-1:0] step,
   output logic [WIDTH-1:0]   shifted
);

   always_comb begin
      // NOTE: kept as if/else so the signed >>> is not turned unsigned by a mixed-sign ?: expression.
      if (arith) begin
         shifted = $unsigned($signed(value) >>> step);
      end else begin
         shifted = value >> step;
      end
   end

endmodule

// File: rtl/shift_right_seq.sv
// Multi-cycle SRL/SRA unit for the MIPS ALU; define SHIFT_RIGHT_MULTIBIT_EN
// to retire four bit positions per cycle while the remaining count allows it.
module shift_right_seq
   import shift_pkg::*;
#(
   parameter int WIDTH   = WIDTH_DEFAULT,
   parameter int SHAMT_W = SHAMT_W_DEFAULT
) (
   input  logic             clk,
   input  logic             rst_n,
   shift_right_seq_if.slave bus
);

   state_t             state_q, state_d;
   logic [SHAMT_W-1:0] count_q;
   logic [SHAMT_W-1:0] step_sz;
   logic               arith_q;
   logic [WIDTH-1:0]   value_q;
   logic [WIDTH-1:0]   step_out;

`ifdef SHIFT_RIGHT_MULTIBIT_EN
   assign step_sz = (count_q >= SHAMT_W'(MULTIBIT_STEP)) ? SHAMT_W'(MULTIBIT_STEP)
                                                        : SHAMT_W'(1);
`else
   assign step_sz = SHAMT_W'(1);
`endif

   shift_right_step #(
      .WIDTH   (WIDTH),
      .SHAMT_W (SHAMT_W)
   ) u_step (
      .value   (value_q),
      .arith   (arith_q),
      .step    (step_sz),
      .shifted (step_out)
   );

   always_comb begin
      // NOTE: default first so every path assigns state_d and no latch is inferred.
      state_d = state_q;
      unique case (state_q)
         IDLE: begin
            if (bus.start) begin
               state_d = (bus.shamt != '0) ? SHIFT : DONE;
            end
         end
         SHIFT: begin
            // The step that brings the count to zero is the last one.
            if (count_q == step_sz) begin
               state_d = DONE;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments only.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         count_q <= '0;
         arith_q <= 1'b0;
         value_q <= '0;
      end else begin
         state_q <= state_d;
         unique case (state_q)
            IDLE: begin
               if (bus.start) begin
                  value_q <= bus.value_in;
                  count_q <= bus.shamt;
                  arith_q <= bus.arith;
               end
            end
            SHIFT: begin
               value_q <= step_out;
               count_q <= count_q - step_sz;
            end
            default: ;
         endcase
      end
   end

   assign bus.busy      = (state_q != IDLE);
   assign bus.done      = (state_q == DONE);
   assign bus.value_out = value_q;

endmodule
